// File: rtl/spi_aes_slave_if_if.sv
// Bundle between the SPI AES responder and its surroundings: the serial lines
// from the master plus the start/done handshake towards the AES core.
interface spi_aes_slave_if_if #(
   parameter int DATA_W = 128,
   parameter int KEY_W  = 128
);
   logic              sclk;
   logic              CS;
   logic              MOSI;
   logic              MISO;
   logic              mode;
   logic              core_start;
   logic              core_mode;
   logic [DATA_W-1:0] core_msg;
   logic [KEY_W-1:0]  core_key;
   logic              core_done;
   logic [DATA_W-1:0] core_result;
   logic              busy;
   logic              frame_err;

   modport slave (
      input  sclk, CS, MOSI, mode, core_done, core_result,
      output MISO, core_start, core_mode, core_msg, core_key, busy, frame_err
   );

   modport master (
      output sclk, CS, MOSI, mode, core_done, core_result,
      input  MISO, core_start, core_mode, core_msg, core_key, busy, frame_err
   );
endinterface

// File: rtl/spi_aes_slave_if.sv
// SPI responder for the AES core: oversamples sclk/CS/MOSI, receives message and
// key LSB-first, runs the core handshake and shifts the result back on MISO.
module spi_aes_slave_if #(
   parameter int DATA_W = 128,
   parameter int KEY_W  = 128
) (
   input  logic               clk,
   input  logic               reset,
   spi_aes_slave_if_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, RX_MSG, RX_KEY, CORE, TX, ABORT} state_t;

   localparam logic [8:0] MSG_LAST = 9'(DATA_W - 1);
   localparam logic [8:0] KEY_LAST = 9'(KEY_W - 1);
   // Bit 1 is CS: its synchronizer idles at the inactive level so a reset
   // never looks like a frame start.
   localparam logic [2:0] SYNC_INIT = 3'b010;

   logic [2:0] async_in;
   logic [2:0] sync_vec;
   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_dly_reg;
   logic       sclk_rise;

   assign async_in = {bus.MOSI, bus.CS, bus.sclk};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               meta_reg <= SYNC_INIT[gi];
               sync_reg <= SYNC_INIT[gi];
            end else begin
               meta_reg <= async_in[gi];
               sync_reg <= meta_reg;
            end
         end
         assign sync_vec[gi] = sync_reg;
      end
   endgenerate

   assign sclk_s    = sync_vec[0];
   assign cs_s      = sync_vec[1];
   assign mosi_s    = sync_vec[2];
   assign sclk_rise = sclk_s & ~sclk_dly_reg;

   state_t            state_reg, state_next;
   logic [8:0]        cnt_reg, cnt_next;
   logic [DATA_W-1:0] msg_reg, msg_next;
   logic [KEY_W-1:0]  key_reg, key_next;
   logic [DATA_W-1:0] tx_reg, tx_next;
   logic              start_reg, start_next;
   logic              mode_reg, mode_next;
   logic              err_reg, err_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_dly_reg <= 1'b0;
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         msg_reg      <= '0;
         key_reg      <= '0;
         tx_reg       <= '0;
         start_reg    <= 1'b0;
         mode_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         sclk_dly_reg <= sclk_s;
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         msg_reg      <= msg_next;
         key_reg      <= key_next;
         tx_reg       <= tx_next;
         start_reg    <= start_next;
         mode_reg     <= mode_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      msg_next   = msg_reg;
      key_next   = key_reg;
      tx_next    = tx_reg;
      start_next = 1'b0;
      mode_next  = mode_reg;
      err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!cs_s) state_next = RX_MSG;
         end
         RX_MSG: begin
            if (cs_s) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (sclk_rise) begin
               msg_next = {mosi_s, msg_reg[DATA_W-1:1]};
               if (cnt_reg == MSG_LAST) state_next = RX_KEY;
               else                     cnt_next   = cnt_reg + 9'd1;
            end
         end
         RX_KEY: begin
            if (cs_s) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (sclk_rise) begin
               key_next = {mosi_s, key_reg[KEY_W-1:1]};
               if (cnt_reg == KEY_LAST) begin
                  start_next = 1'b1;
                  mode_next  = bus.mode;
                  state_next = CORE;
               end else begin
                  cnt_next = cnt_reg + 9'd1;
               end
            end
         end
         CORE: begin
            // An abort coinciding with core_done drops the result and skips ABORT.
            if (cs_s) begin
               err_next   = 1'b1;
               state_next = bus.core_done ? IDLE : ABORT;
            end else if (bus.core_done) begin
               tx_next    = bus.core_result;
               state_next = TX;
            end
         end
         TX: begin
            if (cs_s) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (sclk_rise) begin
               tx_next = tx_reg >> 1;
               if (cnt_reg == MSG_LAST) state_next = IDLE;
               else                     cnt_next   = cnt_reg + 9'd1;
            end
         end
         ABORT: begin
            if (bus.core_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (state_next != state_reg) cnt_next = '0;
   end

   assign bus.MISO       = (state_reg == TX) & tx_reg[0];
   assign bus.busy       = (state_reg != IDLE);
   assign bus.core_start = start_reg;
   assign bus.core_mode  = mode_reg;
   assign bus.core_msg   = msg_reg;
   assign bus.core_key   = key_reg;
   assign bus.frame_err  = err_reg;
endmodule

// File: tb/tb_spi_aes_slave_if.sv
// Self-checking bench for spi_aes_slave_if: a 128-bit-key and a 256-bit-key
// instance driven by a bit-level SPI master and a stand-in AES core.
module tb_spi_aes_slave_if;
   localparam int HP = 5;

   typedef struct {
      logic [127:0] msg;
      logic [255:0] key;
      logic         mode;
      logic [127:0] res;
      int           lat;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset, sclk, mosi, mode, core_done, cs_a, cs_b, sel;
   logic [127:0] core_result;

   always #5 clk = ~clk;

   spi_aes_slave_if_if #(.DATA_W(128), .KEY_W(128)) bus_a();
   spi_aes_slave_if_if #(.DATA_W(128), .KEY_W(256)) bus_b();

   assign bus_a.sclk        = sclk;
   assign bus_a.CS          = cs_a;
   assign bus_a.MOSI        = mosi;
   assign bus_a.mode        = mode;
   assign bus_a.core_done   = core_done;
   assign bus_a.core_result = core_result;
   assign bus_b.sclk        = sclk;
   assign bus_b.CS          = cs_b;
   assign bus_b.MOSI        = mosi;
   assign bus_b.mode        = mode;
   assign bus_b.core_done   = core_done;
   assign bus_b.core_result = core_result;

   spi_aes_slave_if #(.DATA_W(128), .KEY_W(128)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   spi_aes_slave_if #(.DATA_W(128), .KEY_W(256)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   logic         miso_w, start_w, busy_w, ferr_w, mode_w;
   logic [127:0] msg_w;
   logic [255:0] key_w;

   always_comb begin
      if (sel) begin
         miso_w = bus_b.MISO; start_w = bus_b.core_start; busy_w = bus_b.busy;
         ferr_w = bus_b.frame_err; mode_w = bus_b.core_mode; msg_w = bus_b.core_msg;
         key_w  = bus_b.core_key;
      end else begin
         miso_w = bus_a.MISO; start_w = bus_a.core_start; busy_w = bus_a.busy;
         ferr_w = bus_a.frame_err; mode_w = bus_a.core_mode; msg_w = bus_a.core_msg;
         key_w  = {128'h0, bus_a.core_key};
      end
   end

   int           n_cmp = 0, n_err = 0, start_cnt = 0, ferr_cnt = 0;
   logic [127:0] cap_msg = '0;
   logic [255:0] cap_key = '0;
   logic         cap_mode = 1'b0;

   always @(negedge clk) begin
      if (start_w) begin
         start_cnt <= start_cnt + 1;
         cap_msg   <= msg_w;
         cap_key   <= key_w;
         cap_mode  <= mode_w;
      end
      if (ferr_w) ferr_cnt <= ferr_cnt + 1;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cs(input logic v);
      if (sel) cs_b = v;
      else     cs_a = v;
   endtask

   task automatic send_bit(input logic b);
      sclk = 1'b0; mosi = b; tick(HP);
      sclk = 1'b1; tick(HP);
   endtask

   task automatic pulse_done(input logic [127:0] r);
      core_done = 1'b1; core_result = r; tick(1);
      core_done = 1'b0; core_result = '0;
   endtask

   // Shift in message then key; core_start must follow the final bit, not precede it.
   task automatic send_input(input vec_t v, input int kw);
      int s0;
      s0 = start_cnt;
      mode = v.mode;
      set_cs(1'b0);
      tick(10);
      for (int i = 0; i < 128 + kw; i++) begin
         if (i == 128 + kw - 1) chk("start_before_last_bit", 256'(start_cnt - s0), 256'd0);
         if (i < 128) send_bit(v.msg[i]);
         else         send_bit(v.key[i-128]);
      end
      tick(3);
      chk("start_pulses", 256'(start_cnt - s0), 256'd1);
      chk("core_msg", {128'h0, cap_msg}, {128'h0, v.msg});
      chk("core_key", cap_key, v.key);
      chk("core_mode", {255'h0, cap_mode}, {255'h0, v.mode});
      mode = ~v.mode;
   endtask

   // Master samples MISO at the end of each low phase; CS rises one clk after the last rise.
   task automatic recv_bits(input int n, output logic [127:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         sclk = 1'b0; tick(HP);
         got[i] = miso_w;
         sclk = 1'b1;
         if (i == 127) begin
            tick(1); set_cs(1'b1); tick(HP - 1);
         end else begin
            tick(HP);
         end
      end
   endtask

   task automatic run_frame(input vec_t v, input int kw, input int idx);
      int           e0;
      logic [127:0] got;
      e0 = ferr_cnt;
      send_input(v, kw);
      chk("busy_in_core", {255'h0, busy_w}, 256'd1);
      chk("miso_in_core", {255'h0, miso_w}, 256'd0);
      tick(v.lat);
      pulse_done(v.res);
      tick(2);
      recv_bits(128, got);
      tick(10);
      chk("miso_result", {128'h0, got}, {128'h0, v.res});
      chk("frame_err_count", 256'(ferr_cnt - e0), 256'd0);
      chk("busy_after_frame", {255'h0, busy_w}, 256'd0);
      chk("core_mode_held", {255'h0, mode_w}, {255'h0, v.mode});
      $display("frame %0d: keyw=%0d mode=%0d res=%h got=%h", idx, kw, v.mode, v.res, got);
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.msg  = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.key  = {128'h0, $urandom(), $urandom(), $urandom(), $urandom()};
      v.mode = 1'($urandom_range(0, 1));
      v.res  = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.lat  = int'($urandom_range(3, 40));
      return v;
   endfunction

   vec_t tbl [5];

   initial begin
      vec_t         v;
      int           e0, s0, bad;
      logic [127:0] got;

      tbl[0] = '{msg: 128'h3243f6a8885a308d313198a2e0370734,
                 key: 256'h2b7e151628aed2a6abf7158809cf4f3c,
                 mode: 1'b0, res: 128'h3925841d02dc09fbdc118597196a0b32, lat: 20};
      tbl[1] = '{msg: 128'h3925841d02dc09fbdc118597196a0b32,
                 key: 256'h2b7e151628aed2a6abf7158809cf4f3c,
                 mode: 1'b1, res: 128'h3243f6a8885a308d313198a2e0370734, lat: 20};
      for (int i = 2; i < 5; i++) tbl[i] = rand_vec();

      reset = 1'b0; sclk = 1'b0; mosi = 1'b0; mode = 1'b0; core_done = 1'b0;
      core_result = '0; cs_a = 1'b1; cs_b = 1'b1; sel = 1'b0;
      tick(3);
      chk("reset_miso", {255'h0, miso_w}, 256'd0);
      chk("reset_busy", {255'h0, busy_w}, 256'd0);
      chk("reset_start", {255'h0, start_w}, 256'd0);
      chk("reset_ferr", {255'h0, ferr_w}, 256'd0);
      chk("reset_msg_key", {msg_w, key_w[127:0]}, 256'd0);
      reset = 1'b1;
      tick(5);

      for (int i = 0; i < 5; i++) run_frame(tbl[i], 128, i);

      // CS rises after 60 message bits
      e0 = ferr_cnt; s0 = start_cnt;
      set_cs(1'b0); tick(10);
      for (int i = 0; i < 60; i++) send_bit(1'($urandom_range(0, 1)));
      set_cs(1'b1); tick(6);
      chk("early_cs_ferr", 256'(ferr_cnt - e0), 256'd1);
      chk("early_cs_busy", {255'h0, busy_w}, 256'd0);
      chk("early_cs_no_start", 256'(start_cnt - s0), 256'd0);
      $display("early CS abort after 60 bits done");
      run_frame(rand_vec(), 128, 5);

      // CS rises in CORE; core_done arrives 30 cycles later
      v = rand_vec(); e0 = ferr_cnt; bad = 0;
      send_input(v, 128);
      tick(5); set_cs(1'b1);
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (!busy_w || miso_w) bad++;
      end
      chk("abort_busy_miso", 256'(bad), 256'd0);
      chk("abort_ferr", 256'(ferr_cnt - e0), 256'd1);
      pulse_done(~v.res);
      tick(3);
      chk("abort_busy_after_done", {255'h0, busy_w}, 256'd0);
      chk("abort_miso_after_done", {255'h0, miso_w}, 256'd0);
      $display("CS in CORE abort done");
      run_frame(rand_vec(), 128, 6);

      // CS seen high in the very cycle core_done is presented
      v = rand_vec(); e0 = ferr_cnt;
      send_input(v, 128);
      tick(5); set_cs(1'b1); tick(2);
      pulse_done(v.res);
      tick(2);
      chk("done_abort_busy", {255'h0, busy_w}, 256'd0);
      chk("done_abort_ferr", 256'(ferr_cnt - e0), 256'd1);
      chk("done_abort_miso", {255'h0, miso_w}, 256'd0);
      $display("CS with core_done abort done");

      // Reset after 40 output bits
      v = rand_vec();
      send_input(v, 128);
      tick(v.lat); pulse_done(v.res); tick(2);
      recv_bits(40, got);
      chk("tx_first_40_bits", {216'h0, got[39:0]}, {216'h0, v.res[39:0]});
      reset = 1'b0;
      #1;
      chk("midtx_reset_miso", {255'h0, miso_w}, 256'd0);
      chk("midtx_reset_busy", {255'h0, busy_w}, 256'd0);
      chk("midtx_reset_msg", {128'h0, msg_w}, 256'd0);
      chk("midtx_reset_key", key_w, 256'd0);
      set_cs(1'b1); tick(2);
      reset = 1'b1; tick(5);
      $display("reset mid-TX done");
      run_frame(rand_vec(), 128, 7);

      // 256-bit key instance
      sel = 1'b1; tick(2);
      v = rand_vec();
      v.key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      run_frame(v, 256, 8);
      sel = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
